// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared helpers for the serial pattern detector: state width
//               and the prefix/border next-state table built at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int c_MAX_PATTERN_W = 16;
    localparam int c_ENTRY_W       = 4;
    localparam int c_TBL_W         = c_MAX_PATTERN_W * 2 * c_ENTRY_W;

    function automatic int state_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Longest proper prefix of the pattern that is a suffix of
    // (first k pattern bits, b); capping at pw-1 turns a full match into its border.
    function automatic logic [c_ENTRY_W-1:0] next_prefix(
        input logic [c_MAX_PATTERN_W-1:0] pat,
        input int                         pw,
        input int                         k,
        input logic                       b
    );
        int   lmax;
        int   j;
        logic ok;
        logic found;
        logic s_bit;
        next_prefix = '0;
        found       = 1'b0;
        lmax        = (k + 1 < pw - 1) ? k + 1 : pw - 1;
        for (int l = lmax; l > 0; l--) begin
            ok = 1'b1;
            for (int m = 0; m < l; m++) begin
                j     = k + 1 - l + m;
                s_bit = (j == k) ? b : pat[pw - 1 - j];
                if (s_bit != pat[pw - 1 - m]) ok = 1'b0;
            end
            if (ok && !found) begin
                next_prefix = c_ENTRY_W'(l);
                found       = 1'b1;
            end
        end
    endfunction

    // Entry for (state k, input bit b) lives at bit offset (2*k + b) * c_ENTRY_W.
    function automatic logic [c_TBL_W-1:0] build_next_table(
        input logic [c_MAX_PATTERN_W-1:0] pat,
        input int                         pw
    );
        build_next_table = '0;
        for (int k = 0; k < pw; k++) begin
            for (int b = 0; b < 2; b++) begin
                build_next_table[(k * 2 + b) * c_ENTRY_W +: c_ENTRY_W] =
                    next_prefix(pat, pw, k, b[0]);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign sat   = w_sat;

endmodule
`default_nettype wire

// File: rtl/seq_detector_p.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_p
// Description : Parameterised serial pattern detector with registered match
//               pulse, prefix-length state output and saturating match count.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_p
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8,
    localparam int                  SW        = state_width(PATTERN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             i,
    output logic             y,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam logic [c_TBL_W-1:0] c_NEXT_TBL =
        build_next_table(c_MAX_PATTERN_W'(PATTERN), PATTERN_W);
    localparam logic [SW-1:0] c_S0   = '0;
    localparam logic [SW-1:0] c_LAST = SW'(PATTERN_W - 1);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_state_nxt;
    logic          r_y;
    logic          w_y_nxt;
    logic          w_match;
    logic [SW+2:0] w_tbl_base;

    assign w_tbl_base = {r_state, i, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = 1'b0;
        w_match     = 1'b0;
        if (clear) begin
            w_state_nxt = c_S0;
        end else if (in_valid) begin
            w_match     = (r_state == c_LAST) && (i == PATTERN[0]);
            // On a match the table entry already holds the pattern's border.
            w_state_nxt = c_NEXT_TBL[w_tbl_base +: SW];
            if (w_match) begin
                w_y_nxt = 1'b1;
                if (!OVERLAP) w_state_nxt = c_S0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (w_match),
        .count (match_count),
        .sat   (cnt_sat)
    );

    assign y     = r_y;
    assign state = r_state;

endmodule
`default_nettype wire
